tmds_hdmi_encoder: RTL and testbench

Full single-channel HDMI TMDS encoder. Transition-minimisation (stage 1) and DC-balancing (stage 2) are integrated in one block, behind an optional pipeline register. Beyond DVI video/control, it adds HDMI modes: TERC4 data-island symbols, video guard bands and data-island guard bands. One instance per TMDS lane, placed between the pixel/packet mux and the 10:1 serializer.

---
 rtl/tmds_hdmi_encoder.sv | 175 +++++++++++++++++
 tb/tb_tmds_hdmi_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_hdmi_encoder.sv
// Single-lane HDMI TMDS encoder: 8b/10b video with DC balancing, control,
// TERC4 data-island and guard-band symbols, optional stage-1/stage-2 register.
module tmds_hdmi_encoder #(
    parameter int CHANNEL = 0,
    parameter int REG_QM  = 1,
    parameter int DISP_W  = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [2:0]               i_mode,
    input  logic [7:0]               i_data,
    input  logic                     i_c0,
    input  logic                     i_c1,
    input  logic [3:0]               i_terc4,
    output logic [9:0]               o_data,
    output logic signed [DISP_W-1:0] o_disp
);

    localparam logic [2:0] MODE_VIDEO = 3'd1;
    localparam logic [2:0] MODE_TERC4 = 3'd2;
    localparam logic [2:0] MODE_VGB   = 3'd3;
    localparam logic [2:0] MODE_IGB   = 3'd4;
    localparam int         CH         = (CHANNEL > 2) ? 2 : CHANNEL;

    function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
        logic [9:0] s;
        unique case ({c1, c0})
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] t);
        logic [9:0] s;
        unique case (t)
            4'd0:    s = 10'b1010011100;
            4'd1:    s = 10'b1001100011;
            4'd2:    s = 10'b1011100100;
            4'd3:    s = 10'b1011100010;
            4'd4:    s = 10'b0101110001;
            4'd5:    s = 10'b0100011110;
            4'd6:    s = 10'b0110001110;
            4'd7:    s = 10'b0100111100;
            4'd8:    s = 10'b1011001100;
            4'd9:    s = 10'b0100111001;
            4'd10:   s = 10'b0110011100;
            4'd11:   s = 10'b1011000110;
            4'd12:   s = 10'b1010001110;
            4'd13:   s = 10'b1001110001;
            4'd14:   s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Stage 1: transition minimisation
    logic [3:0] n1_data;
    logic       use_xnor;
    logic [8:0] qm_d;

    always_comb begin
        n1_data = '0;
        for (int i = 0; i < 8; i++) begin
            n1_data = n1_data + {3'b000, i_data[i]};
        end
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !i_data[0]);
        qm_d[0]  = i_data[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ i_data[i]) : (qm_d[i-1] ^ i_data[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    logic [8:0] s2_qm;
    logic [2:0] s2_mode;
    logic       s2_c0;
    logic       s2_c1;
    logic [3:0] s2_terc4;

    // Symbol side-band travels with q_m so every field stays aligned.
    if (REG_QM != 0) begin : g_qm_reg
        logic [8:0] qm_q;
        logic [2:0] mode_q;
        logic       c0_q;
        logic       c1_q;
        logic [3:0] terc4_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                qm_q    <= '0;
                mode_q  <= '0;
                c0_q    <= 1'b0;
                c1_q    <= 1'b0;
                terc4_q <= '0;
            end else begin
                qm_q    <= qm_d;
                mode_q  <= i_mode;
                c0_q    <= i_c0;
                c1_q    <= i_c1;
                terc4_q <= i_terc4;
            end
        end

        assign s2_qm    = qm_q;
        assign s2_mode  = mode_q;
        assign s2_c0    = c0_q;
        assign s2_c1    = c1_q;
        assign s2_terc4 = terc4_q;
    end else begin : g_qm_bypass
        assign s2_qm    = qm_d;
        assign s2_mode  = i_mode;
        assign s2_c0    = i_c0;
        assign s2_c1    = i_c1;
        assign s2_terc4 = i_terc4;
    end

    // Stage 2: DC balancing and symbol selection
    logic [9:0]               data_d;
    logic [9:0]               data_q;
    logic signed [DISP_W-1:0] disp_d;
    logic signed [DISP_W-1:0] disp_q;
    int                       n1_qm;
    int                       diff;
    int                       cnt;
    int                       delta;

    always_comb begin
        n1_qm = 0;
        for (int i = 0; i < 8; i++) begin
            n1_qm = n1_qm + (s2_qm[i] ? 1 : 0);
        end
        diff   = 2 * n1_qm - 8;
        cnt    = int'(disp_q);
        delta  = 0;
        data_d = ctrl_sym(s2_c1, s2_c0);
        disp_d = '0;
        case (s2_mode)
            MODE_VIDEO: begin
                if (cnt == 0 || diff == 0) begin
                    data_d = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
                    delta  = s2_qm[8] ? diff : -diff;
                end else if ((cnt > 0 && diff > 0) || (cnt < 0 && diff < 0)) begin
                    data_d = {1'b1, s2_qm[8], ~s2_qm[7:0]};
                    delta  = (s2_qm[8] ? 2 : 0) - diff;
                end else begin
                    data_d = {1'b0, s2_qm[8], s2_qm[7:0]};
                    delta  = diff - (s2_qm[8] ? 0 : 2);
                end
                disp_d = DISP_W'(cnt + delta);
            end
            MODE_TERC4: data_d = terc4_sym(s2_terc4);
            MODE_VGB:   data_d = (CH == 1) ? 10'b0100110011 : 10'b1011001100;
            MODE_IGB:   data_d = (CH == 0) ? terc4_sym({2'b11, s2_c1, s2_c0})
                                           : 10'b0100110011;
            default:    data_d = ctrl_sym(s2_c1, s2_c0);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= 10'b1101010100;
            disp_q <= '0;
        end else begin
            data_q <= data_d;
            disp_q <= disp_d;
        end
    end

    assign o_data = data_q;
    assign o_disp = disp_q;

endmodule

// File: tb/tb_tmds_hdmi_encoder.sv
// Scoreboard bench for tmds_hdmi_encoder: four lane/channel variants at latency 2
// and one at latency 1 share the same stimulus; a negedge monitor checks them.
module tb_tmds_hdmi_encoder;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [2:0] i_mode  = 3'd1;
    logic [7:0] i_data  = 8'h00;
    logic       i_c0    = 1'b0;
    logic       i_c1    = 1'b0;
    logic [3:0] i_terc4 = 4'd0;

    logic [9:0]        od  [5];
    logic signed [4:0] odp [5];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int         tgt;
        int         dut;
        int         kind;   // 0: exact symbol+disparity, 1: decode back to pixel
        logic [9:0] data;
        int         disp;
        logic [7:0] pix;
        int         tag;
    } exp_t;

    exp_t  sb[$];
    string names[$];
    exp_t  e;

    tmds_hdmi_encoder #(.CHANNEL(0), .REG_QM(1), .DISP_W(5)) u_c0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_data(i_data), .i_c0(i_c0),
        .i_c1(i_c1), .i_terc4(i_terc4), .o_data(od[0]), .o_disp(odp[0]));
    tmds_hdmi_encoder #(.CHANNEL(1), .REG_QM(1), .DISP_W(5)) u_c1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_data(i_data), .i_c0(i_c0),
        .i_c1(i_c1), .i_terc4(i_terc4), .o_data(od[1]), .o_disp(odp[1]));
    tmds_hdmi_encoder #(.CHANNEL(2), .REG_QM(1), .DISP_W(5)) u_c2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_data(i_data), .i_c0(i_c0),
        .i_c1(i_c1), .i_terc4(i_terc4), .o_data(od[2]), .o_disp(odp[2]));
    tmds_hdmi_encoder #(.CHANNEL(3), .REG_QM(1), .DISP_W(5)) u_c3 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_data(i_data), .i_c0(i_c0),
        .i_c1(i_c1), .i_terc4(i_terc4), .o_data(od[3]), .o_disp(odp[3]));
    tmds_hdmi_encoder #(.CHANNEL(0), .REG_QM(0), .DISP_W(5)) u_r0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_data(i_data), .i_c0(i_c0),
        .i_c1(i_c1), .i_terc4(i_terc4), .o_data(od[4]), .o_disp(odp[4]));

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] r;
        d    = s[9] ? ~s[7:0] : s[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return r;
    endfunction

    task automatic push(input int tgt, input int dut, input int kind, input logic [9:0] d,
                        input int disp, input logic [7:0] pix, input int tag);
        exp_t x;
        x.tgt  = tgt;
        x.dut  = dut;
        x.kind = kind;
        x.data = d;
        x.disp = disp;
        x.pix  = pix;
        x.tag  = tag;
        sb.push_back(x);
    endtask

    function automatic int new_tag(input string nm);
        names.push_back(nm);
        return names.size() - 1;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // e0/e1/e2: expected symbol on lane 0/1/2 (lane-3 instance behaves as lane 2).
    task automatic send(input logic [2:0] m, input logic [7:0] d, input logic c1,
                        input logic c0, input logic [3:0] t, input logic [9:0] e0,
                        input logic [9:0] e1, input logic [9:0] e2, input int disp,
                        input string nm, input bit p_slow = 1'b1, input bit p_fast = 1'b1);
        int tag;
        tag     = new_tag(nm);
        i_mode  = m;
        i_data  = d;
        i_c1    = c1;
        i_c0    = c0;
        i_terc4 = t;
        if (p_slow) begin
            push(cyc + 2, 0, 0, e0, disp, 8'h00, tag);
            push(cyc + 2, 1, 0, e1, disp, 8'h00, tag);
            push(cyc + 2, 2, 0, e2, disp, 8'h00, tag);
            push(cyc + 2, 3, 0, e2, disp, 8'h00, tag);
        end
        if (p_fast) push(cyc + 1, 4, 0, e0, disp, 8'h00, tag);
        tick();
    endtask

    task automatic vid(input logic [7:0] d, input logic [9:0] ex, input int disp,
                       input string nm, input bit p_slow = 1'b1, input bit p_fast = 1'b1);
        send(3'd1, d, 1'b0, 1'b0, 4'd0, ex, ex, ex, disp, nm, p_slow, p_fast);
    endtask

    task automatic vid_rand(input logic [7:0] d);
        int tag;
        tag    = new_tag("random_video_decode");
        i_mode = 3'd1;
        i_data = d;
        for (int k = 0; k < 4; k++) push(cyc + 2, k, 1, 10'h000, 0, d, tag);
        push(cyc + 1, 4, 1, 10'h000, 0, d, tag);
        tick();
    endtask

    task automatic rst_hold(input string nm);
        int tag;
        tag     = new_tag(nm);
        i_rst_n = 1'b0;
        for (int k = 0; k < 5; k++) push(cyc, k, 0, 10'h354, 0, 8'h00, tag);
        tick();
    endtask

    // Latency-2 lanes emit the reset-state control symbol one cycle after release.
    task automatic release_rst(input string nm);
        int tag;
        tag     = new_tag(nm);
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) push(cyc + 1, k, 0, 10'h354, 0, 8'h00, tag);
    endtask

    always @(negedge i_clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tgt <= cyc) begin
                e = sb[i];
                sb.delete(i);
                if (e.tgt < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s dut%0d: expectation for cycle %0d missed at cycle %0d",
                             names[e.tag], e.dut, e.tgt, cyc);
                end else if (e.kind == 0) begin
                    checks++;
                    if (od[e.dut] !== e.data) begin
                        errors++;
                        $display("FAIL %s dut%0d cyc%0d: o_data got 0x%03h want 0x%03h",
                                 names[e.tag], e.dut, cyc, od[e.dut], e.data);
                    end
                    checks++;
                    if (int'(odp[e.dut]) != e.disp) begin
                        errors++;
                        $display("FAIL %s dut%0d cyc%0d: o_disp got %0d want %0d",
                                 names[e.tag], e.dut, cyc, odp[e.dut], e.disp);
                    end
                end else begin
                    checks++;
                    if (tmds_decode(od[e.dut]) !== e.pix) begin
                        errors++;
                        $display("FAIL %s dut%0d cyc%0d: decoded 0x%02h want 0x%02h",
                                 names[e.tag], e.dut, cyc, tmds_decode(od[e.dut]), e.pix);
                    end
                    checks++;
                    if (int'(odp[e.dut]) > 10 || int'(odp[e.dut]) < -10) begin
                        errors++;
                        $display("FAIL %s dut%0d cyc%0d: |o_disp| got %0d want <= 10",
                                 names[e.tag], e.dut, cyc, odp[e.dut]);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        i_data = 8'hA5;
        repeat (3) rst_hold("reset_hold");

        release_rst("release_ctrl");
        vid(8'h00, 10'h100, -8, "vid00_1");
        vid(8'h00, 10'h3FF, 2, "vid00_2");
        vid(8'h00, 10'h100, -6, "vid00_3");
        vid(8'h00, 10'h3FF, 4, "vid00_4");
        vid(8'h00, 10'h100, -4, "vid00_5");
        vid(8'h00, 10'h3FF, 6, "vid00_6");
        vid(8'h00, 10'h100, -2, "vid00_7");
        vid(8'h00, 10'h3FF, 8, "vid00_8");
        vid(8'h00, 10'h100, 0, "vid00_9");

        send(3'd0, 8'hFF, 1'b0, 1'b0, 4'd0, 10'h354, 10'h354, 10'h354, 0, "ctrl_00");
        send(3'd0, 8'hFF, 1'b0, 1'b1, 4'd0, 10'h0AB, 10'h0AB, 10'h0AB, 0, "ctrl_01");
        send(3'd0, 8'hFF, 1'b1, 1'b0, 4'd0, 10'h154, 10'h154, 10'h154, 0, "ctrl_10");
        send(3'd0, 8'hFF, 1'b1, 1'b1, 4'd0, 10'h2AB, 10'h2AB, 10'h2AB, 0, "ctrl_11");

        send(3'd2, 8'h00, 1'b0, 1'b0, 4'd0, 10'h29C, 10'h29C, 10'h29C, 0, "terc4_0");
        send(3'd2, 8'h00, 1'b0, 1'b0, 4'd13, 10'h271, 10'h271, 10'h271, 0, "terc4_13");
        send(3'd2, 8'h00, 1'b0, 1'b0, 4'd15, 10'h2C3, 10'h2C3, 10'h2C3, 0, "terc4_15");

        vid(8'hFF, 10'h200, -8, "vidFF_xnor");
        vid(8'h00, 10'h3FF, 2, "vid00_invert");
        vid(8'h0F, 10'h105, -2, "vid0F_tie_xor");
        vid(8'h10, 10'h1F0, -2, "vid10_balanced");
        vid(8'h55, 10'h133, -2, "vid55_balanced");
        vid(8'h08, 10'h1F8, 0, "vid08_plain");
        vid(8'hAA, 10'h233, 0, "vidAA_tie_xnor");

        send(3'd2, 8'h00, 1'b0, 1'b0, 4'd0, 10'h29C, 10'h29C, 10'h29C, 0, "terc4_between");
        vid(8'h00, 10'h100, -8, "vid_after_terc4");
        vid(8'hFF, 10'h0FF, -2, "vidFF_plain_1");
        vid(8'hFF, 10'h0FF, 4, "vidFF_plain_2");
        vid(8'hFF, 10'h200, -4, "vidFF_invert");

        send(3'd3, 8'h00, 1'b0, 1'b0, 4'd0, 10'h2CC, 10'h133, 10'h2CC, 0, "video_guard");
        send(3'd4, 8'h00, 1'b0, 1'b1, 4'd0, 10'h271, 10'h133, 10'h133, 0, "island_guard_01");
        send(3'd4, 8'h00, 1'b1, 1'b0, 4'd0, 10'h163, 10'h133, 10'h133, 0, "island_guard_10");
        send(3'd5, 8'h00, 1'b1, 1'b1, 4'd0, 10'h2AB, 10'h2AB, 10'h2AB, 0, "mode5_ctrl");
        send(3'd7, 8'h00, 1'b0, 1'b0, 4'd0, 10'h354, 10'h354, 10'h354, 0, "mode7_ctrl");

        vid(8'h00, 10'h100, -8, "pre_reset_1");
        vid(8'h00, 10'h3FF, 2, "pre_reset_2", 1'b0, 1'b1);
        vid(8'h00, 10'h000, 0, "pre_reset_3", 1'b0, 1'b0);
        repeat (2) rst_hold("midstream_reset");
        release_rst("midstream_release_ctrl");
        vid(8'h00, 10'h100, -8, "vid_after_reset");

        for (int n = 0; n < 1000; n++) vid_rand(8'($urandom));

        i_mode = 3'd0;
        repeat (4) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
